// File: rtl/fan_speed_ctrl.sv
// Fan duty sequencer: derives a target duty from temperature or a manual request,
// then drives the PWM duty through OFF -> full-duty KICK -> rate-limited RUN.
module fan_speed_ctrl #(
    parameter logic [7:0] T_LOW        = 8'd25,
    parameter logic [7:0] T_HIGH       = 8'd40,
    parameter logic [7:0] HYST         = 8'd2,
    parameter logic [7:0] SPD_MIN      = 8'd64,
    parameter logic [7:0] SPD_MAX      = 8'd255,
    parameter logic [7:0] STEP_PER_DEG = 8'd8,
    parameter int         RAMP_DIV     = 256,
    parameter logic [7:0] RAMP_STEP    = 8'd1,
    parameter int         KICK_CYC     = 50000
) (
    input  logic       arst,
    input  logic       clk,
    input  logic [7:0] temp,
    input  logic       temp_valid,
    input  logic       manual_en,
    input  logic [7:0] manual_speed,
    output logic [7:0] speed,
    output logic       fan_on,
    output logic       kicking,
    output logic       at_target
);

    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int KW = (KICK_CYC > 1) ? $clog2(KICK_CYC) : 1;
    localparam logic [PW-1:0] PRE_MAX   = PW'(RAMP_DIV - 1);
    localparam logic [KW-1:0] KICK_LOAD = KW'(KICK_CYC - 1);
    localparam logic [7:0]    T_OFF     = (T_LOW > HYST) ? T_LOW - HYST : 8'd0;

    typedef enum logic [1:0] {ST_OFF, ST_KICK, ST_RUN} state_t;

    state_t        state_q, state_d;
    logic [7:0]    temp_q;
    logic [7:0]    target_q, target_d;
    logic [7:0]    speed_q, speed_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [KW-1:0] kick_cnt_q, kick_cnt_d;
    logic          fan_on_q, fan_on_d;
    logic          kicking_q, kicking_d;

    logic [17:0]   over_deg;
    logic [17:0]   duty_calc;
    logic [7:0]    auto_duty;
    logic [7:0]    man_duty;
    logic          auto_on;
    logic          tick;
    logic [7:0]    ramp_next;

    // NOTE: defaults are assigned first so no path through the block leaves a variable unassigned (no latch).
    always_comb begin
        over_deg  = '0;
        if (temp_q >= T_LOW) begin
            over_deg = {10'd0, temp_q - T_LOW};
        end
        duty_calc = {10'd0, SPD_MIN} + over_deg * {10'd0, STEP_PER_DEG};
        if (temp_q >= T_HIGH || duty_calc > {10'd0, SPD_MAX}) begin
            auto_duty = SPD_MAX;
        end else begin
            auto_duty = duty_calc[7:0];
        end

        // Hysteresis: turn-on at T_LOW, turn-off only below the saturated T_LOW-HYST.
        if (target_q == 8'd0) begin
            auto_on = (temp_q >= T_LOW);
        end else begin
            auto_on = (temp_q >= T_OFF);
        end

        man_duty = (manual_speed < SPD_MIN) ? SPD_MIN : manual_speed;
        if (man_duty > SPD_MAX) begin
            man_duty = SPD_MAX;
        end

        target_d = 8'd0;
        if (manual_en) begin
            if (manual_speed != 8'd0) begin
                target_d = man_duty;
            end
        end else if (auto_on) begin
            target_d = auto_duty;
        end
    end

    assign tick = (state_q == ST_RUN) && (presc_q == PRE_MAX);

    // Next-state logic: FSM transitions, kick countdown and ramp prescaler.
    always_comb begin
        state_d    = state_q;
        kick_cnt_d = kick_cnt_q;
        presc_d    = '0;
        case (state_q)
            ST_OFF: begin
                if (target_q != 8'd0) begin
                    state_d    = ST_KICK;
                    kick_cnt_d = KICK_LOAD;
                end
            end
            ST_KICK: begin
                if (target_q == 8'd0 || kick_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    kick_cnt_d = kick_cnt_q - KW'(1);
                end
            end
            ST_RUN: begin
                if (target_q == 8'd0 && speed_q == 8'd0) begin
                    state_d = ST_OFF;
                end
            end
            default: state_d = ST_OFF;
        endcase
        if (state_q == ST_RUN && state_d == ST_RUN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    // Ramp step toward target; clamps to target so it never overshoots or wraps.
    always_comb begin
        ramp_next = speed_q;
        if (speed_q < target_q) begin
            ramp_next = (target_q - speed_q < RAMP_STEP) ? target_q : speed_q + RAMP_STEP;
        end else if (speed_q > target_q) begin
            ramp_next = (speed_q - target_q < RAMP_STEP) ? target_q : speed_q - RAMP_STEP;
        end
    end

    // Registered outputs derive from the next state so they line up with speed.
    always_comb begin
        speed_d   = speed_q;
        fan_on_d  = (state_d != ST_OFF);
        kicking_d = (state_d == ST_KICK);
        case (state_d)
            ST_OFF:  speed_d = 8'd0;
            ST_KICK: speed_d = SPD_MAX;
            default: speed_d = tick ? ramp_next : speed_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q    <= ST_OFF;
            temp_q     <= 8'd0;
            target_q   <= 8'd0;
            speed_q    <= 8'd0;
            presc_q    <= '0;
            kick_cnt_q <= '0;
            fan_on_q   <= 1'b0;
            kicking_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            if (temp_valid) begin
                temp_q <= temp;
            end
            target_q   <= target_d;
            speed_q    <= speed_d;
            presc_q    <= presc_d;
            kick_cnt_q <= kick_cnt_d;
            fan_on_q   <= fan_on_d;
            kicking_q  <= kicking_d;
        end
    end

    assign speed     = speed_q;
    assign fan_on    = fan_on_q;
    assign kicking   = kicking_q;
    assign at_target = (speed_q == target_q) && (state_q == ST_RUN);

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Scoreboard bench for fan_speed_ctrl: each expected change of {speed, fan_on, kicking}
// is queued with the cycles it should hold before it, and popped when the outputs change.
module tb_fan_speed_ctrl;

    localparam logic [7:0] SPD_MIN   = 8'd64;
    localparam logic [7:0] SPD_MAX   = 8'd255;
    localparam int         RAMP_DIV  = 4;
    localparam int         RAMP_STEP = 4;
    localparam int         KICK_CYC  = 8;
    localparam int         BUDGET    = 1000;

    logic       arst;
    logic       clk;
    logic [7:0] temp;
    logic       temp_valid;
    logic       manual_en;
    logic [7:0] manual_speed;
    logic [7:0] speed;
    logic       fan_on;
    logic       kicking;
    logic       at_target;

    typedef struct packed {
        logic [7:0]  spd;
        logic        on;
        logic        kick;
        logic [15:0] gap;   // cycles since previous change; 0 = not checked
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    fan_speed_ctrl #(
        .T_LOW(8'd25), .T_HIGH(8'd40), .HYST(8'd2), .SPD_MIN(SPD_MIN), .SPD_MAX(SPD_MAX),
        .STEP_PER_DEG(8'd8), .RAMP_DIV(RAMP_DIV), .RAMP_STEP(8'(RAMP_STEP)), .KICK_CYC(KICK_CYC)
    ) dut (
        .arst(arst), .clk(clk), .temp(temp), .temp_valid(temp_valid),
        .manual_en(manual_en), .manual_speed(manual_speed),
        .speed(speed), .fan_on(fan_on), .kicking(kicking), .at_target(at_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic push(input int s, input bit on, input bit k, input int g);
        exp_t e;
        e.spd  = 8'(s);
        e.on   = on;
        e.kick = k;
        e.gap  = 16'(g);
        exp_q.push_back(e);
    endtask

    task automatic push_kick();
        push(SPD_MAX, 1'b1, 1'b1, 0);
        push(SPD_MAX, 1'b1, 1'b0, KICK_CYC);
    endtask

    // Expected ramp: RAMP_STEP per tick toward the target, last step clamped.
    task automatic push_ramp(input int from, input int to, input int first_gap);
        int s = from;
        int g = first_gap;
        while (s != to) begin
            if (to > s) s = (to - s < RAMP_STEP) ? to : s + RAMP_STEP;
            else        s = (s - to < RAMP_STEP) ? to : s - RAMP_STEP;
            push(s, 1'b1, 1'b0, g);
            g = RAMP_DIV;
        end
    endtask

    task automatic push_off();
        push(0, 1'b0, 1'b0, 1);
    endtask

    task automatic strobe(input int t);
        @(negedge clk);
        temp       = 8'(t);
        temp_valid = 1'b1;
        @(negedge clk);
        temp_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < BUDGET) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Output monitor: every change of the output tuple must match the queue head.
    logic [9:0] prev_tup = '0;
    int         gap_cnt  = 0;
    always @(negedge clk) begin
        logic [9:0] cur;
        exp_t       e;
        cur = {speed, fan_on, kicking};
        gap_cnt++;
        if (cur !== prev_tup) begin
            if (exp_q.size() == 0) begin
                check("spurious_change", 32'(cur), 32'(prev_tup));
            end else begin
                e = exp_q.pop_front();
                check("speed", 32'(speed), 32'(e.spd));
                check("fan_on", 32'(fan_on), 32'(e.on));
                check("kicking", 32'(kicking), 32'(e.kick));
                if (e.gap != 0) check("hold_cycles", 32'(gap_cnt), 32'(e.gap));
            end
            prev_tup = cur;
            gap_cnt  = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        arst         = 1'b0;
        temp         = 8'd20;
        temp_valid   = 1'b1;
        manual_en    = 1'b0;
        manual_speed = 8'd0;

        // Reset hold, then release with a cold sample: must stay off.
        repeat (3) @(negedge clk);
        check("rst_speed", 32'(speed), 0);
        check("rst_fan_on", 32'(fan_on), 0);
        check("rst_kicking", 32'(kicking), 0);
        check("rst_at_target", 32'(at_target), 0);
        arst = 1'b1;
        repeat (2) @(negedge clk);
        temp_valid = 1'b0;
        repeat (40) @(negedge clk);
        check("cold_fan_on", 32'(fan_on), 0);
        check("cold_speed", 32'(speed), 0);

        // Auto start at 30 C: kick, then ramp down to 104.
        push_kick();
        push_ramp(255, 104, RAMP_DIV);
        strobe(30);
        drain("auto_start_done");
        check("auto_at_target", 32'(at_target), 1);
        repeat (20) @(negedge clk);
        check("auto_hold_speed", 32'(speed), 104);

        // Hysteresis band holds SPD_MIN; below T_LOW-HYST shuts down.
        push_ramp(104, 64, 0);
        strobe(24);
        drain("hyst_24_done");
        check("hyst_24_at_target", 32'(at_target), 1);
        strobe(23);
        repeat (20) @(negedge clk);
        check("hyst_23_speed", 32'(speed), 64);
        check("hyst_23_fan_on", 32'(fan_on), 1);
        push_ramp(64, 0, 0);
        push_off();
        strobe(22);
        drain("shutdown_done");
        check("shutdown_fan_on", 32'(fan_on), 0);

        // Saturation: T_HIGH and a large sample both give SPD_MAX with no wrap.
        push_kick();
        push_ramp(255, 64, RAMP_DIV);
        strobe(25);
        drain("tlow_start_done");
        push_ramp(64, 255, 0);
        strobe(40);
        drain("thigh_ramp_done");
        check("thigh_speed", 32'(speed), 255);
        strobe(200);
        repeat (30) @(negedge clk);
        check("t200_speed", 32'(speed), 255);
        check("t200_at_target", 32'(at_target), 1);
        push_ramp(255, 0, 0);
        push_off();
        strobe(0);
        drain("sat_shutdown_done");

        // Manual override: small request clamps to SPD_MIN.
        push_kick();
        push_ramp(255, 64, RAMP_DIV);
        @(negedge clk);
        manual_en    = 1'b1;
        manual_speed = 8'd10;
        drain("manual_start_done");
        check("manual_speed_clamped", 32'(speed), 64);
        check("manual_at_target", 32'(at_target), 1);
        push_ramp(64, 0, 0);
        push_off();
        @(negedge clk);
        manual_speed = 8'd0;
        drain("manual_off_done");

        // Kick aborted by manual_speed=0 during kick cycle 3.
        push(SPD_MAX, 1'b1, 1'b1, 0);
        push(SPD_MAX, 1'b1, 1'b0, 4);
        push_ramp(255, 0, RAMP_DIV);
        push_off();
        @(negedge clk);
        manual_speed = 8'd10;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (kicking) break;
        end
        check("abort_kick_seen", 32'(kicking), 1);
        repeat (2) @(negedge clk);
        manual_speed = 8'd0;
        drain("abort_done");
        manual_en = 1'b0;

        // Asynchronous reset mid-ramp at speed 180, then a full restart.
        push_kick();
        push_ramp(255, 64, RAMP_DIV);
        strobe(25);
        drain("pre_reset_start_done");
        push_ramp(64, 180, 0);
        strobe(40);
        drain("reach_180_done");
        check("pre_reset_speed", 32'(speed), 180);
        #2;
        push(0, 1'b0, 1'b0, 0);
        arst = 1'b0;
        #1;
        check("async_rst_speed", 32'(speed), 0);
        check("async_rst_fan_on", 32'(fan_on), 0);
        check("async_rst_kicking", 32'(kicking), 0);
        repeat (2) @(negedge clk);
        arst = 1'b1;
        repeat (10) @(negedge clk);
        check("post_reset_fan_on", 32'(fan_on), 0);
        push_kick();
        push_ramp(255, 104, RAMP_DIV);
        strobe(30);
        drain("restart_done");
        check("restart_speed", 32'(speed), 104);
        check("restart_at_target", 32'(at_target), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fan_speed_ctrl.md
Name: fan_speed_ctrl

Overview:
- Closed-loop sequencer for the fan PWM stage.
- Takes temperature samples from the sensor path, or a manual override from the home controller, and computes a target duty.
- Sequences start-up: a full-duty kick, then a rate-limited ramp.
- Drives the 8-bit duty command consumed by the PWM generator.
- Hysteresis on turn-off keeps the fan from chattering around the low threshold.

Parameters:
- T_LOW, 8'd25: temperature (°C) at/above which the fan turns on in auto mode.
- T_HIGH, 8'd40: temperature at/above which auto target = SPD_MAX.
- HYST, 8'd2: turn-off hysteresis; fan turns off only when temp < T_LOW-HYST.
- SPD_MIN, 8'd64: minimum non-zero duty; any non-zero target is clamped up to this.
- SPD_MAX, 8'd255: maximum duty, and the kick duty.
- STEP_PER_DEG, 8'd8: duty increment per °C above T_LOW in auto mode.
- RAMP_DIV, 256: clk cycles per ramp tick (>=1).
- RAMP_STEP, 8'd1: max duty change per ramp tick.
- KICK_CYC, 50000: cycles held at SPD_MAX after leaving OFF (>=1).

Ports:
- arst  in  1  reset, asynchronous, active-low.
- clk  in  1  clock, posedge.
- temp  in  8  unsigned temperature sample, °C.
- temp_valid  in  1  one-cycle strobe; temp is sampled when high.
- manual_en  in  1  level; 1 selects manual_speed as the target source.
- manual_speed  in  8  manual duty request; 0 = off.
- speed  out  8  registered duty command to the PWM block.
- fan_on  out  1  registered; 1 in any state other than OFF.
- kicking  out  1  registered; 1 in KICK.
- at_target  out  1  combinational: speed==target && state==RUN.

Behaviour:
- Reset (arst low, any time, including mid-kick or mid-ramp): speed=0, target=0, temp_q=0, state=OFF, prescaler=0, kick counter=0, fan_on=0, kicking=0. Takes effect immediately; no ramp-down.
- temp_q: loads temp on the clk edge where temp_valid=1; otherwise holds.
- Target register updates every cycle (1-cycle latency from temp_q / manual inputs).
- Target, manual mode (manual_en=1):
  - manual_speed=0 -> target=0.
  - else target=max(manual_speed, SPD_MIN).
  - Hysteresis is not applied.
- Target, auto mode (manual_en=0):
  - If target==0: temp_q>=T_LOW -> compute; else stays 0.
  - If target!=0: temp_q<T_LOW-HYST -> 0; else compute.
  - T_LOW-HYST saturates at 0.
  - compute = min(SPD_MAX, SPD_MIN + sat(temp_q-T_LOW)*STEP_PER_DEG), evaluated at >=16-bit width.
  - sat(x) is 0 for temp_q<T_LOW (hysteresis band yields SPD_MIN).
  - temp_q>=T_HIGH -> SPD_MAX.
- Switching manual_en takes effect on the next target update. speed is never stepped directly by a switch; the ramp handles it.
- Prescaler: counts 0..RAMP_DIV-1 in RUN only; tick when it equals RAMP_DIV-1, then wraps to 0. Cleared in OFF and KICK.
- FSM, state OFF:
  - speed=0.
  - target!=0 -> KICK next cycle: speed=SPD_MAX, kick counter=KICK_CYC-1.
- FSM, state KICK:
  - speed held at SPD_MAX; counter decrements each cycle.
  - Counter==0 -> RUN.
  - target==0 during KICK -> RUN immediately (kick aborted); speed then ramps down from SPD_MAX.
- FSM, state RUN:
  - On tick: speed moves toward target by RAMP_STEP, clamped so it never overshoots (|diff|<RAMP_STEP -> speed=target).
  - No tick -> speed holds.
  - target==0 && speed==0 -> OFF next cycle.
  - A target change mid-ramp redirects the ramp; no restart and no re-kick.
- speed never exceeds SPD_MAX and never wraps. In RUN with target!=0, speed may be below SPD_MIN only transiently.
- fan_on and kicking are registered from next-state, so they are aligned with speed.

Test Plan:
Sim params for all cases: T_LOW=25, T_HIGH=40, HYST=2, SPD_MIN=64, SPD_MAX=255, STEP_PER_DEG=8, RAMP_DIV=4, RAMP_STEP=4, KICK_CYC=8.
1. Reset checks:
   - Hold arst low -> speed=0, fan_on=0, kicking=0, at_target=0.
   - Release with temp=20 valid -> stays OFF indefinitely.
2. Auto start:
   - temp=30 strobe -> target=104.
   - Speed goes 0 -> 255 within 2 cycles; kicking=1 for 8 cycles.
   - Then speed drops by 4 every 4 cycles: 251, 247, ...
   - Final step clamps to 104; at_target=1 and speed holds.
3. Hysteresis and shutdown:
   - From steady 104: temp=24 -> target=64, ramps to 64, fan stays on.
   - temp=23 -> still 64.
   - temp=22 -> target=0, ramps down 4/tick; OFF (fan_on=0) one cycle after speed=0.
4. Saturation and overflow:
   - temp=40 -> target 255.
   - temp=200 -> target 255 with no wrap.
   - Ramp from 64 reaches exactly 255 with no overshoot.
5. Manual override:
   - manual_en=1, manual_speed=10 while OFF -> kick, then settles at 64 (clamp).
   - manual_speed=0 during KICK (cycle 3) -> kicking drops next cycle, ramp-down from 255 to 0, then OFF.
6. Async reset mid-ramp:
   - Assert arst at speed=180 between clock edges -> speed=0 and fan_on=0 immediately.
   - After release, re-strobe temp=30 -> full kick sequence repeats.
